// File: rtl/alu_mult_seq.sv
// Sequential MULT/MULTU unit: radix-2 shift-add multiply on the shared ALU.
// Owns the ALU for 32 iterations, then writes the signed-corrected product to HI/LO.
module alu_mult_seq #(
  parameter logic [3:0] ALU_ADD  = 4'd0,
  parameter logic [3:0] ALU_IDLE = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_own,
  output logic [3:0]  alu_alucnt,
  output logic [31:0] alu_input1,
  output logic [31:0] alu_input2,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [31:0] a_q, b_q;
  logic        sgn_q, neg;
  logic [31:0] mcand, acc_hi, acc_lo;
  logic [4:0]  cnt;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod;
  logic        carry;

  assign mag_a = (sgn_q && a_q[31]) ? 32'd0 - a_q : a_q;
  assign mag_b = (sgn_q && b_q[31]) ? 32'd0 - b_q : b_q;
  // An unsigned wrap of the ALU sum is the carry out of bit 31
  assign carry = alu_result < acc_hi;
  assign prod  = neg ? 64'd0 - {acc_hi, acc_lo} : {acc_hi, acc_lo};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: state_nx = S_ITER;
      S_ITER: if (cnt == 5'd31) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      neg    <= 1'b0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= op_a;
            b_q   <= op_b;
            sgn_q <= is_signed;
          end
        end
        S_LOAD: begin
          mcand  <= mag_a;
          acc_lo <= mag_b;
          acc_hi <= '0;
          neg    <= sgn_q & (a_q[31] ^ b_q[31]);
          cnt    <= '0;
        end
        S_ITER: begin
          {acc_hi, acc_lo} <= {carry, alu_result, acc_lo[31:1]};
          cnt              <= cnt + 5'd1;
        end
        S_FIX: begin
          hi <= prod[63:32];
          lo <= prod[31:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = state != S_IDLE;
    done       = state == S_DONE;
    alu_own    = state == S_ITER;
    alu_alucnt = ALU_IDLE;
    alu_input1 = '0;
    alu_input2 = '0;
    alu_shamt  = '0;
    if (alu_own) begin
      alu_alucnt = ALU_ADD;
      alu_input1 = acc_hi;
      alu_input2 = acc_lo[0] ? mcand : '0;
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: random and corner MULT/MULTU against a
// plain-arithmetic product model, plus timing, ALU-ownership and reset checks.
module tb_alu_mult_seq;

  logic        clk = 0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a, op_b;
  logic        busy, done, alu_own;
  logic [31:0] hi, lo;
  logic [3:0]  alu_alucnt;
  logic [31:0] alu_input1, alu_input2, alu_result;
  logic [4:0]  alu_shamt;

  int tests = 0;
  int fails = 0;
  logic [63:0] last = '0;

  always #5 clk = ~clk;

  // Shared ALU: alucnt 0 is add
  assign alu_result = (alu_alucnt == 4'd0) ? alu_input1 + alu_input2 : 32'd0;

  alu_mult_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_own(alu_own), .alu_alucnt(alu_alucnt), .alu_input1(alu_input1),
    .alu_input2(alu_input2), .alu_shamt(alu_shamt), .alu_result(alu_result)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, b,
                                        input bit s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // poke: pulse start with junk operands mid-iteration
  // rst_at: assert reset in that cycle (0 = never)
  task automatic do_mult(input logic [31:0] a, b, input bit s,
                         input bit poke, input int rst_at);
    logic [63:0] exp;
    logic [31:0] mag_a;
    int n, busy_n, own_n, bad_alu, bad_hold;
    bit got_done;
    exp = model(a, b, s);
    mag_a = (s && a[31]) ? 32'd0 - a : a;
    @(negedge clk);
    op_a = a; op_b = b; is_signed = s; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom);
    n = 0; busy_n = 0; own_n = 0; bad_alu = 0; bad_hold = 0;
    got_done = 0;
    while (!got_done && n < 100) begin
      @(negedge clk);
      n++;
      if (rst_at != 0 && n == rst_at) begin
        rst_n = 0;
        @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_own", {63'd0, alu_own}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1;
        last = '0;
        return;
      end
      if (busy) busy_n++;
      if (alu_own) begin
        own_n++;
        if (alu_alucnt != 4'd0 || alu_shamt != 0) bad_alu++;
        if (alu_input2 != 0 && (alu_input2 != mag_a || b == 0)) bad_alu++;
      end else if (alu_input1 != 0 || alu_input2 != 0 || alu_shamt != 0) begin
        bad_alu++;
      end
      if (poke && n == 10) begin
        start = 1; op_a = $urandom; op_b = $urandom;
      end
      if (poke && n == 11) start = 0;
      if (done) got_done = 1;
      else if ({hi, lo} != last) bad_hold++;
    end
    check("latency", 64'(n), 64'd35);
    check("busy_cycles", 64'(busy_n), 64'd35);
    check("own_cycles", 64'(own_n), 64'd32);
    check("alu_bus", 64'(bad_alu), 64'd0);
    check("hilo_hold", 64'(bad_hold), 64'd0);
    check("product", {hi, lo}, exp);
    last = exp;
    @(negedge clk);
    check("idle_after", {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    rst_n = 0; start = 0; is_signed = 0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {59'd0, busy, done, alu_own, alu_alucnt == 4'd0,
                          alu_shamt == 5'd0}, 64'd3);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1;

    do_mult(32'd7, 32'd6, 0, 0, 0);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    do_mult(32'hFFFF_FFFD, 32'd5, 1, 0, 0);
    do_mult(32'h8000_0000, 32'h8000_0000, 1, 0, 0);
    do_mult(32'h8000_0000, 32'd1, 1, 0, 0);
    do_mult(32'h0001_2345, 32'h0000_0ABC, 0, 1, 0);
    do_mult(32'h1234_5678, 32'h0000_0009, 0, 0, 12);
    do_mult(32'd2, 32'd3, 0, 0, 0);
    do_mult(32'd5, 32'd0, 0, 0, 0);

    for (int i = 0; i < 24; i++)
      do_mult(pick(), pick(), 1'($urandom), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
